seq_alu_core: RTL and testbench

Parametrised multi-cycle sequential ALU: controller FSM plus iterative datapath for add, subtract, shift-add multiply and restoring divide on WIDTH-bit unsigned operands. Sits between the register/operand source and result sink of the sequential ALU. Supersedes the fixed-width 2-bit-opcode control unit, adding a datapath, a busy/done handshake, back-to-back issue and divide-by-zero reporting.

---
 rtl/seq_alu_pkg.sv | 32 +++
 rtl/seq_alu_dp.sv | 93 +++++++++
 rtl/seq_alu_core.sv | 111 +++++++++++
 tb/tb_seq_alu_core.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared types and helpers for the sequential ALU: opcode/state encodings
// and the number of EXEC edges each operation occupies.
package seq_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2,
        ST_RSVD = 2'd3
    } state_e;

    // Divide by zero skips the iterations and finishes in a single edge.
    function automatic int unsigned iter_count(input op_e op, input logic b_zero,
                                               input int unsigned width);
        int unsigned n;
        n = 1;
        case (op)
            OP_MUL:  n = width;
            OP_DIV:  n = b_zero ? 1 : width;
            default: n = 1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/seq_alu_dp.sv
// One-step iterative datapath: operand latches, shift-add multiplier and
// restoring divider partials; result_o is the value after the current step.
module seq_alu_dp
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               step_i,
    input  op_e                op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output op_e                op_o,
    output logic               div_zero_o,
    output logic [2*WIDTH-1:0] result_o
);

    op_e                op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   quo_d;

    logic [WIDTH:0]     add_ext;
    logic [WIDTH:0]     sub_ext;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
        end else if (load_i) begin
            op_q     <= op_i;
            a_q      <= a_i;
            b_q      <= b_i;
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            rem_q    <= '0;
            quo_q    <= a_i;
        end else if (step_i) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
        end
    end

    always_comb begin
        add_ext = {1'b0, a_q} + {1'b0, b_q};
        sub_ext = {1'b0, a_q} - {1'b0, b_q};

        acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

        // Bring the next dividend bit into the remainder; keep the trial
        // difference only when it did not go negative.
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, b_q};
        rem_d   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_comb begin
        result_o = '0;
        case (op_q)
            OP_ADD:  result_o = {{(WIDTH-1){1'b0}}, add_ext};
            OP_SUB:  result_o = {{(WIDTH-1){1'b0}}, sub_ext};
            OP_MUL:  result_o = acc_d;
            OP_DIV:  result_o = div_zero_o ? {a_q, {WIDTH{1'b1}}} : {rem_d, quo_d};
            default: result_o = '0;
        endcase
    end

    assign op_o       = op_q;
    assign div_zero_o = (b_q == '0);

endmodule

// File: rtl/seq_alu_core.sv
// Sequential ALU controller: IDLE/EXEC/DONE FSM, iteration counter and the
// architectural result/err registers around the iterative datapath.
module seq_alu_core
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         opcode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [1:0]         cstate
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_e             state_q;
    state_e             state_d;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      cnt_d;
    logic [2*WIDTH-1:0] result_q;
    logic [2*WIDTH-1:0] result_d;
    logic               err_q;
    logic               err_d;

    logic               load;
    logic               step;
    op_e                dp_op;
    logic               dp_div_zero;
    logic [2*WIDTH-1:0] dp_result;
    logic [CW-1:0]      last_cnt;

    seq_alu_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (load),
        .step_i     (step),
        .op_i       (op_e'(opcode)),
        .a_i        (a),
        .b_i        (b),
        .op_o       (dp_op),
        .div_zero_o (dp_div_zero),
        .result_o   (dp_result)
    );

    assign last_cnt = CW'(iter_count(dp_op, dp_div_zero, WIDTH) - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;
        load     = 1'b0;
        step     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (en) begin
                    load    = 1'b1;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                step = 1'b1;
                // The final step's datapath output is committed directly,
                // so result never exposes a partial value.
                if (cnt_q == last_cnt) begin
                    cnt_d    = '0;
                    result_d = dp_result;
                    err_d    = (dp_op == OP_DIV) && dp_div_zero;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign result = result_q;
    assign err    = err_q;
    assign busy   = (state_q == ST_EXEC);
    assign done   = (state_q == ST_DONE);
    assign cstate = state_q;

endmodule

// File: tb/tb_seq_alu_core.sv
// Self-checking bench for seq_alu_core: directed vector table, hand-written
// back-to-back and mid-operation reset sequences, then random ops vs a model.
module tb_seq_alu_core;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [1:0]     opcode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] result;
    logic           busy;
    logic           done;
    logic           err;
    logic [1:0]     cstate;

    int pass_cnt  = 0;
    int total_cnt = 0;

    seq_alu_core #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .opcode (opcode),
        .a      (a),
        .b      (b),
        .result (result),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .cstate (cstate)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [15:0]  res;
        logic         e;
        int           lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input longint unsigned got,
                         input longint unsigned exp);
        total_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    endtask

    // Reference from the arithmetic definitions: op result, err, EXEC edges.
    function automatic void model(input int op, input longint unsigned av,
                                  input longint unsigned bv,
                                  output longint unsigned r, output bit e,
                                  output int n);
        longint unsigned mask;
        mask = (64'd1 << W) - 1;
        e = 1'b0;
        n = 1;
        r = 0;
        case (op)
            0: r = av + bv;
            1: r = ((av - bv) & mask) | ((av < bv) ? (64'd1 << W) : 64'd0);
            2: begin r = av * bv; n = W; end
            default: begin
                if (bv == 0) begin r = (av << W) | mask; e = 1'b1; end
                else begin r = ((av % bv) << W) | (av / bv); n = W; end
            end
        endcase
    endfunction

    // Called at a negedge; issues the op and returns at the negedge where
    // done is seen. lat counts cycles from the accepting edge.
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] aa,
                         input logic [W-1:0] bb, input bit hold,
                         output logic [2*W-1:0] res, output logic e,
                         output int lat, output int busy_n);
        logic [2*W-1:0] prev;
        bit held_ok;
        bit fin;
        en     = 1'b1;
        opcode = op;
        a      = aa;
        b      = bb;
        prev   = result;
        @(posedge clk);
        lat = 0; busy_n = 0; held_ok = 1'b1; fin = 1'b0;
        while (!fin && lat < 100) begin
            @(negedge clk);
            lat++;
            if (!hold) en = 1'b0;
            if (done) fin = 1'b1;
            else begin
                if (busy) busy_n++;
                if (result !== prev || err !== 1'b0) held_ok = 1'b0;
            end
        end
        check("exec_hold", held_ok, 1);
        check("done_seen", fin, 1);
        check("done_state", {busy, cstate}, 3'b010);
        res = result;
        e   = err;
    endtask

    initial begin
        logic [2*W-1:0] r;
        logic e;
        int lat, bn, n;
        longint unsigned er;
        bit ee;
        int op;
        logic [W-1:0] ra, rb;
        bit hold;

        vecs[0] = '{2'd0, 8'd200, 8'd100, 16'h012C, 1'b0, 2};
        vecs[1] = '{2'd1, 8'd5,   8'd7,   16'h01FE, 1'b0, 2};
        vecs[2] = '{2'd1, 8'd7,   8'd5,   16'h0002, 1'b0, 2};
        vecs[3] = '{2'd3, 8'd100, 8'd7,   16'h020E, 1'b0, 9};
        vecs[4] = '{2'd3, 8'd100, 8'd0,   16'h64FF, 1'b1, 2};
        vecs[5] = '{2'd2, 8'd3,   8'd5,   16'h000F, 1'b0, 9};
        vecs[6] = '{2'd0, 8'd255, 8'd255, 16'h01FE, 1'b0, 2};
        vecs[7] = '{2'd1, 8'd0,   8'd0,   16'h0000, 1'b0, 2};
        vecs[8] = '{2'd3, 8'd7,   8'd100, 16'h0700, 1'b0, 9};
        vecs[9] = '{2'd2, 8'd0,   8'd200, 16'h0000, 1'b0, 9};

        rst = 1'b1; en = 1'b1; opcode = 2'd2; a = 8'd13; b = 8'd11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_state", {cstate, busy, done, err, result}, 0);
        end
        rst = 1'b0; en = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, r, e, lat, bn);
            check("vec_result", r, vecs[i].res);
            check("vec_err", e, vecs[i].e);
            check("vec_latency", lat, vecs[i].lat);
            check("vec_busy", bn, vecs[i].lat - 1);
            @(negedge clk);
        end

        // MUL with en held high, then an ADD accepted straight from DONE.
        do_op(2'd2, 8'd255, 8'd255, 1'b1, r, e, lat, bn);
        check("b2b_mul_result", r, 16'hFE01);
        check("b2b_mul_latency", lat, 9);
        check("b2b_mul_busy", bn, 8);
        do_op(2'd0, 8'd10, 8'd20, 1'b0, r, e, lat, bn);
        check("b2b_add_result", r, 16'h001E);
        check("b2b_add_latency", lat, 2);

        // Reset arriving at the 4th EXEC edge of a MUL.
        en = 1'b1; opcode = 2'd2; a = 8'd9; b = 8'd9;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            en = 1'b0;
        end
        check("midmul_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midmul_reset", {cstate, busy, done, err, result}, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midmul_no_done", {cstate, done}, 0);
        end
        do_op(2'd0, 8'd1, 8'd2, 1'b0, r, e, lat, bn);
        check("post_reset_add", r, 16'h0003);
        check("post_reset_latency", lat, 2);
        @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            op = int'($urandom_range(0, 3));
            ra = W'($urandom);
            rb = W'($urandom);
            if (op == 3 && $urandom_range(0, 5) == 0) rb = '0;
            hold = 1'($urandom_range(0, 1));
            model(op, ra, rb, er, ee, n);
            do_op(2'(op), ra, rb, hold, r, e, lat, bn);
            check("rand_result", r, er);
            check("rand_err", e, ee);
            check("rand_latency", lat, n + 1);
            check("rand_busy", bn, n);
            if (!hold && $urandom_range(0, 1) == 1) @(negedge clk);
        end
        en = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
